cpu_burst_sm: RTL and testbench

CPU_BURST_SM -- requirements
Module: cpu_burst_sm

---
 rtl/cpu_sm_pkg.sv | 53 +++++
 rtl/cpu_burst_sm_if.sv | 47 ++++
 rtl/cpu_sm_term.sv | 60 ++++++
 rtl/cpu_burst_sm.sv | 171 +++++++++++++++++
 tb/tb_cpu_burst_sm.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sm_pkg.sv
// cpu_sm_pkg: shared types for the DMA burst bus master.
// State encoding, SIZ codes, DSACK decode values, output bundle.
package cpu_sm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GRANT,
    S_ADDR,
    S_DATA,
    S_TERM,
    S_RELEASE,
    S_ERROR
  } state_e;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_WORD = 2'b10;

  // decode of {DSACK1_, DSACK0_}
  localparam logic [1:0] ACK_P32  = 2'b00;
  localparam logic [1:0] ACK_P16  = 2'b01;
  localparam logic [1:0] ACK_P8   = 2'b10;
  localparam logic [1:0] ACK_NONE = 2'b11;

  typedef struct packed {
    logic       br_n;
    logic       bgack_n;
    logic       as_n;
    logic       ds_n;
    logic       rw;
    logic [1:0] siz;
    logic       a1;
    logic       half_sel;
    logic       pop;
    logic       push;
    logic       incadd;
    logic       busy;
    logic       err;
  } bus_out_t;

  function automatic bus_out_t out_idle();
    bus_out_t o;
    o         = '0;
    o.br_n    = 1'b1;
    o.bgack_n = 1'b1;
    o.as_n    = 1'b1;
    o.ds_n    = 1'b1;
    o.rw      = 1'b1;
    o.siz     = SIZ_LONG;
    return o;
  endfunction

endpackage

// File: rtl/cpu_burst_sm_if.sv
// cpu_burst_sm_if: FIFO status, DMA control and 68k-style bus
// signals between the burst master and its environment.
interface cpu_burst_sm_if;

  logic       DMAENA;
  logic       DMADIR;
  logic       FIFOFULL;
  logic       FIFOEMPTY;
  logic       FLUSHFIFO;
  logic       LASTWORD;
  logic       BG_;
  logic       DSACK0_;
  logic       DSACK1_;
  logic       BERR_;
  logic       BR_;
  logic       BGACK_;
  logic       AS_;
  logic       DS_;
  logic       RW;
  logic [1:0] SIZ;
  logic       A1;
  logic       FIFO_POP;
  logic       FIFO_PUSH;
  logic       HALF_SEL;
  logic       INCADD;
  logic       BUSY;
  logic       ERR;

  modport master (
    input  DMAENA, DMADIR, FIFOFULL, FIFOEMPTY,
    input  FLUSHFIFO, LASTWORD,
    input  BG_, DSACK0_, DSACK1_, BERR_,
    output BR_, BGACK_, AS_, DS_, RW, SIZ, A1,
    output FIFO_POP, FIFO_PUSH, HALF_SEL,
    output INCADD, BUSY, ERR
  );

  modport slave (
    output DMAENA, DMADIR, FIFOFULL, FIFOEMPTY,
    output FLUSHFIFO, LASTWORD,
    output BG_, DSACK0_, DSACK1_, BERR_,
    input  BR_, BGACK_, AS_, DS_, RW, SIZ, A1,
    input  FIFO_POP, FIFO_PUSH, HALF_SEL,
    input  INCADD, BUSY, ERR
  );

endinterface

// File: rtl/cpu_sm_term.sv
// cpu_sm_term: data-phase termination decode (DSACK, BERR,
// timeout) for the burst master.
module cpu_sm_term #(
  parameter int TIMEOUT     = 64,
  parameter int PORT16_ONLY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic active,
  input  logic dsack0_n,
  input  logic dsack1_n,
  input  logic berr_n,
  output logic done_long,
  output logic done_half,
  output logic err
);
  import cpu_sm_pkg::*;

  logic [7:0] tmr_q;
  logic [1:0] ack;
  logic       p16;
  logic       expired;

  assign ack = {dsack1_n, dsack0_n};
  assign p16 = (PORT16_ONLY != 0);

  // last allowed data cycle: the counter hits zero on this edge
  assign expired = (ack == ACK_NONE) && (tmr_q <= 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
    end else if (load) begin
      tmr_q <= 8'(TIMEOUT);
    end else if (active && tmr_q != 8'd0) begin
      tmr_q <= tmr_q - 8'd1;
    end
  end

  always_comb begin
    done_long = 1'b0;
    done_half = 1'b0;
    err       = 1'b0;
    if (active) begin
      err = !berr_n || (ack == ACK_P8) || expired;
      if (!err) begin
        unique case (ack)
          ACK_P32: begin
            done_long = !p16;
            done_half = p16;
          end
          ACK_P16: done_half = 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/cpu_burst_sm.sv
// cpu_burst_sm: DMA burst bus master moving longwords between the
// FIFO and a 16/32-bit asynchronous bus.
module cpu_burst_sm #(
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT     = 64,
  parameter int PORT16_ONLY = 0
) (
  input logic            CLK,
  input logic            RST,
  cpu_burst_sm_if.master bus
);
  import cpu_sm_pkg::*;

  localparam int            CW  = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LEN = CW'(BURST_LEN);

  state_e        state_q;
  state_e        state_d;
  logic          half_q;
  logic          half_d;
  logic          lw_q;
  logic          lw_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  bus_out_t      out_q;
  bus_out_t      out_d;
  logic          t_long;
  logic          t_half;
  logic          t_err;
  logic          start;
  logic          more;

  cpu_sm_term #(
    .TIMEOUT    (TIMEOUT),
    .PORT16_ONLY(PORT16_ONLY)
  ) u_term (
    .clk      (CLK),
    .rst      (RST),
    .load     (state_q == S_ADDR),
    .active   (state_q == S_DATA),
    .dsack0_n (bus.DSACK0_),
    .dsack1_n (bus.DSACK1_),
    .berr_n   (bus.BERR_),
    .done_long(t_long),
    .done_half(t_half),
    .err      (t_err)
  );

  assign start = bus.DMAENA && !out_q.err &&
    (bus.DMADIR ?
      (bus.FIFOFULL || (bus.FLUSHFIFO && !bus.FIFOEMPTY)) :
      !bus.FIFOFULL);

  assign more = (cnt_q < LEN) && bus.DMAENA &&
    !bus.LASTWORD &&
    (bus.DMADIR ? !bus.FIFOEMPTY : !bus.FIFOFULL);

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    lw_d    = lw_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        half_d = 1'b0;
        lw_d   = 1'b0;
        cnt_d  = '0;
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        if (!bus.DMAENA) begin
          state_d = S_IDLE;
        end else if (!bus.BG_ && bus.DSACK0_ &&
                     bus.DSACK1_) begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: state_d = S_ADDR;
      S_ADDR:  state_d = S_DATA;
      S_DATA: begin
        if (t_err) begin
          state_d = S_ERROR;
        end else if (t_long || t_half) begin
          // a half ack on the second half closes the longword
          state_d = S_TERM;
          lw_d    = t_long || half_q;
          if (t_long || half_q) cnt_d = cnt_q + 1'b1;
        end
      end
      S_TERM: begin
        if (!lw_q) begin
          state_d = S_ADDR;
          half_d  = 1'b1;
        end else if (more) begin
          state_d = S_ADDR;
          half_d  = 1'b0;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        cnt_d   = '0;
        half_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        cnt_d  = '0;
        half_d = 1'b0;
        if (!bus.DMAENA) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state and registered
  always_comb begin
    out_d      = out_idle();
    out_d.busy = (state_d != S_IDLE);
    unique case (state_d)
      S_REQ:   out_d.br_n    = 1'b0;
      S_GRANT: out_d.bgack_n = 1'b0;
      S_ADDR, S_DATA, S_TERM: begin
        out_d.bgack_n  = 1'b0;
        out_d.rw       = !bus.DMADIR;
        out_d.siz      = half_d ? SIZ_WORD : SIZ_LONG;
        out_d.a1       = half_d;
        out_d.half_sel = half_d;
        out_d.as_n     = (state_d == S_TERM);
        out_d.ds_n     = (state_d != S_DATA);
        if (state_d == S_TERM && lw_d) begin
          out_d.incadd = 1'b1;
          out_d.pop    = bus.DMADIR;
          out_d.push   = !bus.DMADIR;
        end
      end
      S_ERROR: out_d.err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      half_q  <= 1'b0;
      lw_q    <= 1'b0;
      cnt_q   <= '0;
      out_q   <= out_idle();
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      lw_q    <= lw_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign bus.BR_       = out_q.br_n;
  assign bus.BGACK_    = out_q.bgack_n;
  assign bus.AS_       = out_q.as_n;
  assign bus.DS_       = out_q.ds_n;
  assign bus.RW        = out_q.rw;
  assign bus.SIZ       = out_q.siz;
  assign bus.A1        = out_q.a1;
  assign bus.HALF_SEL  = out_q.half_sel;
  assign bus.FIFO_POP  = out_q.pop;
  assign bus.FIFO_PUSH = out_q.push;
  assign bus.INCADD    = out_q.incadd;
  assign bus.BUSY      = out_q.busy;
  assign bus.ERR       = out_q.err;

endmodule

// File: tb/tb_cpu_burst_sm.sv
// tb_cpu_burst_sm: randomized tenures against a transaction-level
// model of pops, pushes, INCADD and bus-cycle shapes.
module tb_cpu_burst_sm;

  localparam int BL = 4;
  localparam int TO = 64;
  localparam logic [13:0] RST_VEC = 14'b11111_00_0000000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  cpu_burst_sm_if bus();

  cpu_burst_sm #(
    .BURST_LEN  (BL),
    .TIMEOUT    (TO),
    .PORT16_ONLY(0)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // environment knobs (main process owns these)
  bit p16      = 1'b0;
  int ack_mode = 0;
  int err_at   = 0;
  int max_dly  = 3;
  int last_idx = 99;
  int inc_base = 0;

  // responder / monitor owned
  int ack_idx  = 0;
  int ack_wait = 0;
  int bg_wait  = 0;
  int n_pop    = 0;
  int n_push   = 0;
  int n_inc    = 0;
  int ds_run   = 0;
  int ds_last  = 0;
  bit as_prev  = 1'b1;
  logic [4:0] cyc_q[$];

  assign bus.LASTWORD = ((n_inc - inc_base) >= last_idx);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [13:0] out_vec();
    return {bus.BR_, bus.BGACK_, bus.AS_, bus.DS_, bus.RW,
            bus.SIZ, bus.A1, bus.HALF_SEL, bus.FIFO_POP,
            bus.FIFO_PUSH, bus.INCADD, bus.BUSY, bus.ERR};
  endfunction

  // bus grant with random latency
  always @(negedge CLK) begin
    if (RST || bus.BR_ !== 1'b0) begin
      bus.BG_ = 1'b1;
      bg_wait = $urandom_range(3);
    end else if (bg_wait > 0) begin
      bg_wait--;
    end else begin
      bus.BG_ = 1'b0;
    end
  end

  // slave: acks after a random wait, or misbehaves from err_at on
  always @(negedge CLK) begin
    if (RST || bus.DS_ !== 1'b0) begin
      bus.DSACK0_ = 1'b1;
      bus.DSACK1_ = 1'b1;
      bus.BERR_   = 1'b1;
      ack_wait    = $urandom_range(max_dly);
    end else if (ack_wait > 0) begin
      ack_wait--;
    end else if (bus.DSACK0_ && bus.DSACK1_ && bus.BERR_) begin
      if (ack_mode != 0 && ack_idx >= err_at) begin
        case (ack_mode)
          1: begin
            bus.BERR_   = 1'b0;
            bus.DSACK0_ = 1'b0;
            bus.DSACK1_ = 1'b0;
          end
          3: bus.DSACK0_ = 1'b0;
          default: ;
        endcase
      end else begin
        bus.DSACK1_ = 1'b0;
        bus.DSACK0_ = p16;
        ack_idx++;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.FIFO_POP)  n_pop++;
      if (bus.FIFO_PUSH) n_push++;
      if (bus.INCADD)    n_inc++;
      if (!bus.AS_ && as_prev)
        cyc_q.push_back({bus.RW, bus.HALF_SEL, bus.A1, bus.SIZ});
      if (!bus.DS_) begin
        ds_run++;
      end else begin
        if (ds_run > 0) ds_last = ds_run;
        ds_run = 0;
      end
    end
    as_prev = bus.AS_;
  end

  task automatic run_xfer(input bit dir, input bit p16_i,
                          input int mode, input int k,
                          input int last, input bit drop);
    int  b_pop, b_push, b_cyc, nl, ncyc, m;
    bit  seen, done, err_s, as_s, ds_s;
    logic [4:0] want;
    logic a1;
    p16      = p16_i;
    ack_mode = mode;
    err_at   = ack_idx + k;
    last_idx = last;
    inc_base = n_inc;
    max_dly  = $urandom_range(3);
    b_pop    = n_pop;
    b_push   = n_push;
    b_cyc    = cyc_q.size();
    m        = p16_i ? 2 : 1;
    bus.DMADIR    = dir;
    bus.FIFOEMPTY = 1'b0;
    if (dir && $urandom_range(1) == 1) begin
      bus.FIFOFULL  = 1'b0;
      bus.FLUSHFIFO = 1'b1;
    end else begin
      bus.FIFOFULL  = dir;
      bus.FLUSHFIFO = 1'b0;
    end
    bus.DMAENA = 1'b1;
    seen = 0;
    done = 0;
    err_s = 0;
    as_s = 0;
    ds_s = 0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge CLK);
      if (drop && !bus.DS_) bus.DMAENA = 1'b0;
      if (!bus.BGACK_) begin
        seen = 1;
      end else if (seen) begin
        done  = 1;
        err_s = bus.ERR;
        as_s  = bus.AS_;
        ds_s  = bus.DS_;
        bus.DMAENA = 1'b0;
      end
    end
    bus.DMAENA = 1'b0;
    check("tenure_end", done, 1);
    check("err_flag", err_s, (mode != 0));
    if (mode != 0) begin
      check("err_as", as_s, 1);
      check("err_ds", ds_s, 1);
    end
    repeat (3) @(negedge CLK);
    check("busy_after", bus.BUSY, 0);
    check("err_cleared", bus.ERR, 0);
    if (mode == 2) check("ds_timeout", ds_last, TO);
    if (mode != 0) begin
      nl   = k / m;
      ncyc = k + 1;
    end else begin
      nl   = drop ? 1 : ((last < BL) ? last : BL);
      ncyc = nl * m;
    end
    check("incadd", n_inc - inc_base, nl);
    check("pop", n_pop - b_pop, dir ? nl : 0);
    check("push", n_push - b_push, dir ? 0 : nl);
    check("bus_cycles", cyc_q.size() - b_cyc, ncyc);
    for (int i = 0; i < ncyc && b_cyc + i < cyc_q.size(); i++) begin
      a1   = p16_i ? logic'(i % 2) : 1'b0;
      want = {!dir, a1, a1, a1 ? 2'b10 : 2'b00};
      check("cycle_shape", cyc_q[b_cyc + i], want);
    end
    bus.FIFOFULL  = 1'b0;
    bus.FLUSHFIFO = 1'b0;
    last_idx = 99;
    ack_mode = 0;
  endtask

  initial begin
    int mode, k, r;
    bit dir, w16, drop, got_ds;
    bus.DMAENA    = 1'b0;
    bus.DMADIR    = 1'b0;
    bus.FIFOFULL  = 1'b1;
    bus.FIFOEMPTY = 1'b1;
    bus.FLUSHFIFO = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_vec", out_vec(), RST_VEC);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_vec", out_vec(), RST_VEC);

    run_xfer(1, 0, 0, 0, 99, 0);
    run_xfer(0, 1, 0, 0, 99, 0);
    run_xfer(1, 0, 2, 0, 99, 0);
    run_xfer(1, 0, 1, 0, 99, 0);
    run_xfer(0, 0, 3, 1, 99, 0);
    run_xfer(1, 0, 0, 0, 2, 0);
    run_xfer(1, 1, 0, 0, 99, 1);
    run_xfer(0, 1, 2, 3, 99, 0);

    for (int it = 0; it < 24; it++) begin
      dir  = $urandom_range(1);
      w16  = $urandom_range(1);
      r    = $urandom_range(5);
      mode = (r < 3) ? 0 : r - 2;
      drop = 0;
      if (mode != 0) begin
        k = $urandom_range(BL * (w16 ? 2 : 1) - 1);
        run_xfer(dir, w16, mode, k, 99, 0);
      end else begin
        drop = ($urandom_range(3) == 0);
        run_xfer(dir, w16, 0, 0, $urandom_range(6, 1), drop);
      end
    end

    // reset in the middle of a data phase
    p16 = 1'b0;
    max_dly = 3;
    bus.DMADIR   = 1'b1;
    bus.FIFOFULL = 1'b1;
    bus.DMAENA   = 1'b1;
    got_ds = 0;
    for (int c = 0; c < 200 && !got_ds; c++) begin
      @(negedge CLK);
      if (!bus.DS_) got_ds = 1;
    end
    check("rst_reach_data", got_ds, 1);
    RST = 1'b1;
    bus.DMAENA = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_mid_vec", out_vec(), RST_VEC);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_after_vec", out_vec(), RST_VEC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
